// File: rtl/fp_pkg.sv
// fp_pkg: binary32 field widths, special encodings and the unpacked operand view.
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    typedef struct packed {
        logic sign;
        logic [EXP_W-1:0] exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;
endpackage

// File: rtl/fp_lzc_shift.sv
// fp_lzc_shift: 27-bit leading-zero count and left-justifying shift.
module fp_lzc_shift (
    input  logic [26:0] in,
    output logic [4:0]  count,
    output logic [26:0] shifted
);
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++)
            if (in[i]) count = 5'(26 - i);
        shifted = in << count;
    end
endmodule

// File: rtl/fpadd_single.sv
// fpadd_single: two-stage binary32 adder, round-to-nearest-even, flush-to-zero.
module fpadd_single
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] reg_A,
    input  logic [31:0] reg_B,
    output logic [31:0] out
);
    logic [31:0] A_r, B_r, res;
    fp32_t a, b, l, s;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sub, up;
    logic [7:0] d;
    logic [25:0] ext_s, ones, shifted;
    logic sticky;
    logic [26:0] l27, s27, n, sh;
    logic [27:0] sum;
    logic [4:0] lz;
    logic [24:0] m;
    logic [9:0] e, er;
    logic [22:0] frac;
    assign a = A_r;
    assign b = B_r;
    assign a_nan = &a.exp && |a.frac;
    assign b_nan = &b.exp && |b.frac;
    assign a_inf = &a.exp && ~|a.frac;
    assign b_inf = &b.exp && ~|b.frac;
    assign a_zero = ~|a.exp;
    assign b_zero = ~|b.exp;
    fp_lzc_shift norm (.in(sum[26:0]), .count(lz), .shifted(sh));
    always_comb begin
        l = A_r[30:0] >= B_r[30:0] ? a : b;
        s = A_r[30:0] >= B_r[30:0] ? b : a;
        sub = a.sign ^ b.sign;
        d = l.exp - s.exp;
        ext_s = {1'b1, s.frac, 2'b00};
        ones = '1;
        shifted = d >= 8'd26 ? 26'd0 : ext_s >> d;
        sticky = d >= 8'd26 ? 1'b1 : |(ext_s & ~(ones << d));
        s27 = {shifted, sticky};
        l27 = {1'b1, l.frac, 3'b000};
        sum = sub ? {1'b0, l27} - {1'b0, s27} : {1'b0, l27} + {1'b0, s27};
        // carry-out folds the dropped bit into sticky; otherwise left-justify
        n = sum[27] ? {sum[27:2], |sum[1:0]} : sh;
        e = sum[27] ? {2'b00, l.exp} + 10'd1 : {2'b00, l.exp} - {5'd0, lz};
        up = n[2] & (n[1] | n[0] | n[3]);
        m = {1'b0, n[26:3]} + {24'd0, up};
        er = m[24] ? e + 10'd1 : e;
        frac = m[24] ? m[23:1] : m[22:0];
        res = ~|sum ? 32'd0 :
              (!er[9] && er >= 10'd255) ? {l.sign, POS_INF[30:0]} :
              (er[9] || er == 10'd0) ? {l.sign, 31'd0} :
              {l.sign, er[7:0], frac};
        res = (a_nan || b_nan || (a_inf && b_inf && sub)) ? QNAN :
              a_inf ? A_r :
              b_inf ? B_r :
              (a_zero && b_zero) ? {a.sign & b.sign, 31'd0} :
              a_zero ? B_r :
              b_zero ? A_r : res;
    end
    always_ff @(posedge clk)
        if (reset) begin
            A_r <= '0;
            B_r <= '0;
            out <= '0;
        end else begin
            A_r <= reg_A;
            B_r <= reg_B;
            out <= res;
        end
endmodule

// File: tb/tb_fpadd_single.sv
// tb_fpadd_single: directed vector table applied spaced and back-to-back, plus reset sequences.
module tb_fpadd_single;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] reg_A = '0, reg_B = '0, out;
    int checks = 0, errors = 0;
    typedef struct {
        logic [31:0] a, b, exp;
    } vec_t;
    vec_t v[$];
    fpadd_single dut (.clk(clk), .reset(reset), .reg_A(reg_A), .reg_B(reg_B), .out(out));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask
    initial begin
        v.push_back('{32'h3FC00000, 32'h40100000, 32'h40700000});
        v.push_back('{32'h3F800000, 32'hBF400000, 32'h3E800000});
        v.push_back('{32'h3F800000, 32'h33800000, 32'h3F800000});
        v.push_back('{32'h3F800000, 32'h34400000, 32'h3F800002});
        v.push_back('{32'h3F800000, 32'hBF800000, 32'h00000000});
        v.push_back('{32'h80000000, 32'h80000000, 32'h80000000});
        v.push_back('{32'h80000000, 32'h00000000, 32'h00000000});
        v.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000});
        v.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000});
        v.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000});
        v.push_back('{32'h3F800000, 32'h7F800001, 32'h7FC00000});
        v.push_back('{32'hFF800000, 32'h3F800000, 32'hFF800000});
        v.push_back('{32'h00000001, 32'h3F800000, 32'h3F800000});
        v.push_back('{32'h3FFFFFFF, 32'h33800000, 32'h40000000});
        v.push_back('{32'h3FFFFFFF, 32'h34000000, 32'h40000000});
        v.push_back('{32'h00800000, 32'h80C00000, 32'h80000000});
        v.push_back('{32'h40400000, 32'hC0000000, 32'h3F800000});
        v.push_back('{32'h4B800000, 32'h3F800000, 32'h4B800000});
        v.push_back('{32'h4B800000, 32'h40400000, 32'h4B800002});
        v.push_back('{32'h3F800000, 32'h00000000, 32'h3F800000});
        // reset clears everything and dominates operands
        reg_A = 32'h40000000;
        reg_B = 32'h40000000;
        @(posedge clk);
        #1 check("reset_out", out, 32'h00000000);
        @(negedge clk);
        reset = 1'b0;
        reg_A = 32'h3F800000;
        reg_B = 32'h3F800000;
        @(posedge clk);
        #1 check("latency_edge1", out, 32'h00000000);
        @(posedge clk);
        #1 check("latency_edge2", out, 32'h40000000);
        // spaced application
        foreach (v[i]) begin
            @(negedge clk);
            reg_A = v[i].a;
            reg_B = v[i].b;
            @(posedge clk);
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), out, v[i].exp);
        end
        // back-to-back: new pair every cycle, result 2 edges later
        for (int i = 0; i < v.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) check($sformatf("pipe%0d", i - 2), out, v[i-2].exp);
            if (i < v.size()) begin
                reg_A = v[i].a;
                reg_B = v[i].b;
            end
        end
        // swapped operand order must give the same sum
        foreach (v[i]) begin
            @(negedge clk);
            reg_A = v[i].b;
            reg_B = v[i].a;
            @(posedge clk);
            @(posedge clk);
            if (v[i].exp != 32'h00000000 || v[i].a[31] == v[i].b[31])
                #1 check($sformatf("swap%0d", i), out, v[i].exp);
        end
        // mid-stream reset
        @(negedge clk);
        reg_A = 32'h40400000;
        reg_B = 32'h40400000;
        reset = 1'b1;
        @(posedge clk);
        #1 check("midreset_out", out, 32'h00000000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check("midreset_zero", out, 32'h00000000);
        @(posedge clk);
        #1 check("midreset_resume", out, 32'h40C00000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
